// File: rtl/id_ex_skid_reg.sv
// ============================================================================
// Module  : id_ex_skid_reg
// Brief   : Decode->execute pipeline register with a 2-entry skid buffer,
//           valid/ready handshakes on both sides and a synchronous flush.
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_ex_skid_reg #(
  parameter int WORD    = 64,
  parameter int OPC_LEN = 11,
  parameter int CTRL_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [WORD-1:0]    in_pc,
  input  logic [WORD-1:0]    in_rd1,
  input  logic [WORD-1:0]    in_rd2,
  input  logic [WORD-1:0]    in_sext,
  input  logic [OPC_LEN-1:0] in_opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [WORD-1:0]    out_pc,
  output logic [WORD-1:0]    out_rd1,
  output logic [WORD-1:0]    out_rd2,
  output logic [WORD-1:0]    out_sext,
  output logic [OPC_LEN-1:0] out_opcode
);

  localparam int BUNDLE_W = CTRL_W + 4 * WORD + OPC_LEN;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic                main_valid;
  logic                skid_valid;
  logic                in_fire;
  logic                out_fire;
  logic                load_main_in;
  logic                load_main_skid;
  logic                load_skid;
  logic [BUNDLE_W-1:0] in_bundle;
  logic [BUNDLE_W-1:0] main_q;
  logic [BUNDLE_W-1:0] skid_q;
  logic [CTRL_W-1:0]   main_ctrl;

  assign in_bundle = {in_ctrl, in_pc, in_rd1, in_rd2, in_sext, in_opcode};
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (in_fire) state_nxt = ONE;
      ONE: begin
        if (in_fire && !out_fire)      state_nxt = FULL;
        else if (!in_fire && out_fire) state_nxt = EMPTY;
      end
      FULL:    if (out_fire) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
    // Flush outranks every handshake; a consumed entry is simply gone.
    if (flush) state_nxt = EMPTY;
  end

  always_comb begin
    main_valid     = (state == ONE) || (state == FULL);
    skid_valid     = (state == FULL);
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (!flush) begin
      load_main_in   = in_fire && ((state == EMPTY) || ((state == ONE) && out_fire));
      load_skid      = in_fire && (state == ONE) && !out_fire;
      load_main_skid = (state == FULL) && out_fire;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_bundle;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_bundle;
    end
  end

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;

  assign {main_ctrl, out_pc, out_rd1, out_rd2, out_sext, out_opcode} = main_q;
  assign out_ctrl = main_ctrl & {CTRL_W{main_valid}};

endmodule

`default_nettype wire

// File: tb/tb_id_ex_skid_reg.sv
// ============================================================================
// Module  : tb_id_ex_skid_reg
// Brief   : Self-checking bench for id_ex_skid_reg against a queue model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_skid_reg;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_ctrl;
  logic [63:0] in_pc;
  logic [63:0] in_rd1;
  logic [63:0] in_rd2;
  logic [63:0] in_sext;
  logic [10:0] in_opcode;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_ctrl;
  logic [63:0] out_pc;
  logic [63:0] out_rd1;
  logic [63:0] out_rd2;
  logic [63:0] out_sext;
  logic [10:0] out_opcode;

  typedef struct {
    logic [7:0]  ctrl;
    logic [63:0] pc;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] sext;
    logic [10:0] opc;
  } bundle_t;

  bundle_t mq[$];
  int      n_cmp;
  int      n_err;

  id_ex_skid_reg #(.WORD(64), .OPC_LEN(11), .CTRL_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_pc     (in_pc),
    .in_rd1    (in_rd1),
    .in_rd2    (in_rd2),
    .in_sext   (in_sext),
    .in_opcode (in_opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_pc    (out_pc),
    .out_rd1   (out_rd1),
    .out_rd2   (out_rd2),
    .out_sext  (out_sext),
    .out_opcode(out_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model view: the queue head is what execute sees, capacity is two.
  task automatic check_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(mq.size() < 2));
    if (mq.size() > 0) begin
      check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_ctrl"}, 64'(out_ctrl), 64'(mq[0].ctrl));
      check({tag, "_pc"}, out_pc, mq[0].pc);
      check({tag, "_rd1"}, out_rd1, mq[0].rd1);
      check({tag, "_rd2"}, out_rd2, mq[0].rd2);
      check({tag, "_sext"}, out_sext, mq[0].sext);
      check({tag, "_opc"}, 64'(out_opcode), 64'(mq[0].opc));
    end else begin
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_ctrl"}, 64'(out_ctrl), 64'd0);
    end
  endtask

  task automatic put(input bit v, input bit r, input bit f,
                     input logic [63:0] pc, input logic [7:0] ctrl);
    in_valid  = v;
    out_ready = r;
    flush     = f;
    in_pc     = pc;
    in_ctrl   = ctrl;
    in_rd1    = {$urandom, $urandom};
    in_rd2    = {$urandom, $urandom};
    in_sext   = {$urandom, $urandom};
    in_opcode = 11'($urandom);
  endtask

  task automatic step(input string tag);
    bundle_t b;
    bit      inf;
    bit      outf;
    inf    = in_valid && (mq.size() < 2);
    outf   = out_ready && (mq.size() > 0);
    b.ctrl = in_ctrl;
    b.pc   = in_pc;
    b.rd1  = in_rd1;
    b.rd2  = in_rd2;
    b.sext = in_sext;
    b.opc  = in_opcode;
    @(posedge clk);
    if (!reset || flush) begin
      mq.delete();
    end else begin
      if (outf) void'(mq.pop_front());
      if (inf)  mq.push_back(b);
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    put(0, 0, 0, 64'h0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst");
    @(negedge clk);
    reset = 1'b1;

    // Streaming with no gaps.
    put(1, 1, 0, 64'h0, 8'hA5); step("s0"); check("stream0", out_pc, 64'h0);
    put(1, 1, 0, 64'h4, 8'h13); step("s1"); check("stream1", out_pc, 64'h4);
    put(1, 1, 0, 64'h8, 8'h81); step("s2"); check("stream2", out_pc, 64'h8);
    put(0, 1, 0, 64'h0, 8'h00); step("s3");

    // Backpressure then drain; C waits for room.
    put(1, 0, 0, 64'h10, 8'h11); step("bpA");
    put(1, 0, 0, 64'h14, 8'h22); step("bpB");
    check("bp_full_ready", 64'(in_ready), 64'd0);
    check("bp_head", out_pc, 64'h10);
    put(1, 1, 0, 64'h18, 8'h33); step("bpC0");
    check("bp_second", out_pc, 64'h14);
    step("bpC1");
    check("bp_third", out_pc, 64'h18);
    put(0, 1, 0, 64'h0, 8'h00); step("bpD");

    // Flush in FULL with a pending input.
    put(1, 0, 0, 64'h30, 8'h44); step("fl0");
    put(1, 0, 0, 64'h34, 8'h55); step("fl1");
    put(1, 0, 1, 64'h20, 8'hFF); step("fl2");
    check("flush_valid", 64'(out_valid), 64'd0);
    put(0, 1, 0, 64'h0, 8'h00); step("fl3"); step("fl4");
    // Flush in ONE with a same-cycle in_fire.
    put(1, 0, 0, 64'h38, 8'h66); step("fl5");
    put(1, 1, 1, 64'h24, 8'hFF); step("fl6");
    check("flush_one_valid", 64'(out_valid), 64'd0);

    // Simultaneous in/out fire in ONE.
    put(1, 0, 0, 64'h50, 8'h01); step("sim0");
    put(1, 1, 0, 64'h54, 8'h02); step("sim1");
    check("sim_ready", 64'(in_ready), 64'd1);
    check("sim_pc", out_pc, 64'h54);

    // Bubble gating keeps the last data.
    put(1, 1, 0, 64'h40, 8'h08); step("g0");
    check("gate_ctrl_live", 64'(out_ctrl), 64'h08);
    put(0, 1, 0, 64'h0, 8'h00); step("g1");
    check("gate_ctrl", 64'(out_ctrl), 64'h00);
    check("gate_pc_hold", out_pc, 64'h40);

    // Asynchronous reset from FULL, between edges.
    put(1, 0, 0, 64'h60, 8'h77); step("r0");
    put(1, 0, 0, 64'h64, 8'h88); step("r1");
    check("r_full", 64'(in_ready), 64'd0);
    #2;
    reset = 1'b0;
    mq.delete();
    #1;
    check_outputs("arst");
    put(1, 1, 0, 64'h68, 8'h99); step("arst_hold");
    @(negedge clk);
    reset = 1'b1;
    step("arst_first");
    check("arst_first_pc", out_pc, 64'h68);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      put(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 15) == 0), {$urandom, $urandom}, 8'($urandom));
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
